// File: rtl/mult_pkg.sv
// Shared definitions for the matrix-multiply engine: element/word geometry,
// memory region bases, pipeline latencies, the memory port bundle and the
// operation descriptor.
package mult_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int BANDWIDTH  = 8;
  localparam int ADDR_WIDTH = 11;

  localparam logic [ADDR_WIDTH-1:0] DATAA_ADDR = 11'h000;
  localparam logic [ADDR_WIDTH-1:0] DATAB_ADDR = 11'h200;
  localparam logic [ADDR_WIDTH-1:0] RES_ADDR   = 11'h400;

  localparam int MUL_CYCLES = 5;
  localparam int ADD_CYCLES = 7;

  typedef enum logic [7:0] {
    OP_NOP    = 8'h00,
    MAT_MUL   = 8'h01,
    MAT_ADD   = 8'h02,
    MAT_SCALE = 8'h03
  } op_code_e;

  typedef struct packed {
    op_code_e   op_code;
    logic [7:0] dimA1;
    logic [7:0] dimA2;
    logic [7:0] dimB2;
  } meta_data_t;

  typedef struct packed {
    logic                            read;
    logic                            write;
    logic [ADDR_WIDTH-1:0]           address;
    logic [BANDWIDTH*DATA_WIDTH-1:0] writedata;
  } mem_t;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_MUL, S_ADD, S_WRITE, S_DONE
  } state_e;

endpackage

// File: rtl/mult_lane.sv
// One accumulator lane: single-precision multiply of scalar a_i by b_i,
// then accumulate into acc_o. Operands are held stable by the controller for
// the full multiply/add windows, so each core is a multi-cycle path ending in
// a register. Rounding is toward zero; denormals flush to zero.
//   clk, rst_n           clock, async active-low reset
//   a_i, b_i             multiplier operands
//   acc_clr_i            clear accumulator
//   acc_load_i           accumulator <= accumulator + product
//   acc_o                accumulator value
module mult_lane
  import mult_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  acc_clr_i,
  input  logic                  acc_load_i,
  output logic [DATA_WIDTH-1:0] acc_o
);

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0]       p;
    logic signed [9:0] e;
    logic [22:0]       m;
    logic              s;
    s = a[31] ^ b[31];
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'sd1;
    end else begin
      m = p[45:23];
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 0) return 32'd0;
    if (e >= 255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], m};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [24:0]       mx, my, r;
    logic signed [9:0] e;
    if (a[30:23] == 8'd0) return b;
    if (b[30:23] == 8'd0) return a;
    // x is the larger magnitude; it fixes the result sign and exponent
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = x[30:23] - y[30:23];
    mx = {2'b01, x[22:0]};
    my = (d > 8'd24) ? 25'd0 : ({2'b01, y[22:0]} >> d);
    e  = 10'(x[30:23]);
    if (x[31] == y[31]) begin
      r = mx + my;
      if (r[24]) begin
        r = r >> 1;
        e = e + 10'sd1;
      end
    end else begin
      r = mx - my;
      if (r == 25'd0) return 32'd0;
      for (int n = 0; n < 24; n++) begin
        if (!r[23]) begin
          r = r << 1;
          e = e - 10'sd1;
        end
      end
    end
    if (e <= 0) return 32'd0;
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], r[22:0]};
  endfunction

  logic [DATA_WIDTH-1:0] prod_q;
  logic [DATA_WIDTH-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= fp_mul(a_i, b_i);
      if (acc_clr_i)       acc_q <= '0;
      else if (acc_load_i) acc_q <= fp_add(acc_q, prod_q);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mult.sv
// Matrix-multiply controller C = A x B over word-wide memories, 8 lanes wide.
// Each pass reads one A scalar and one B word, multiplies the scalar into all
// 8 lanes and accumulates; after dimA2 passes one C word is written.
//   clock, reset         clock, async active-low reset
//   MatMul_en, op        start request and dimensions (sampled in IDLE only)
//   readdataA/B          read data, valid the cycle after the read strobe
//   memA, memB, memC     word ports (A/B read-only, C write-only)
//   finish               one-cycle completion pulse
//
// state   | meaning
// IDLE    | wait for MatMul_en, latch dimensions, clear counters/accumulator
// READ    | strobe A and B reads for current (i, k, j)
// CAPTURE | latch A scalar (lane k%8) and B word
// MUL     | 5-cycle multiply window, operands held
// ADD     | 7-cycle add window, accumulator loads on last cycle; next k
// WRITE   | write accumulator word to C, advance j / i
// DONE    | finish pulse on first cycle, then hold until MatMul_en drops
module mult
  import mult_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            MatMul_en,
  input  meta_data_t                      op,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0] readdataA,
  input  logic [BANDWIDTH*DATA_WIDTH-1:0] readdataB,
  output mem_t                            memA,
  output mem_t                            memB,
  output mem_t                            memC,
  output logic                            finish
);

  state_e                          state_q, state_d;
  logic [7:0]                      i_q, i_d, k_q, k_d, da1_q, da1_d;
  logic [4:0]                      j_q, j_d, da2w_q, da2w_d, nb_q, nb_d;
  logic [2:0]                      tmr_q, tmr_d;
  logic                            done_q, done_d;
  logic [DATA_WIDTH-1:0]           scalar_q, scalar_d;
  logic [BANDWIDTH*DATA_WIDTH-1:0] bword_q, bword_d;
  logic [BANDWIDTH*DATA_WIDTH-1:0] acc_word;
  logic                            acc_clr, acc_load;
  logic [ADDR_WIDTH-1:0]           addr_a, addr_b, addr_c;

  // Opcode is qualified externally by MatMul_en; low dimension bits are ignored.
  logic unused_op;
  assign unused_op = ^{op.op_code, op.dimA2[2:0], op.dimB2[2:0]};

  // Row lengths are whole words, so A's flat index /8 splits into i*words + k/8.
  assign addr_a = DATAA_ADDR + ADDR_WIDTH'(i_q) * ADDR_WIDTH'(da2w_q) + ADDR_WIDTH'(k_q[7:3]);
  assign addr_b = DATAB_ADDR + ADDR_WIDTH'(k_q) * ADDR_WIDTH'(nb_q) + ADDR_WIDTH'(j_q);
  assign addr_c = RES_ADDR + ADDR_WIDTH'(i_q) * ADDR_WIDTH'(nb_q) + ADDR_WIDTH'(j_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      tmr_q    <= '0;
      da1_q    <= '0;
      da2w_q   <= '0;
      nb_q     <= '0;
      done_q   <= 1'b0;
      scalar_q <= '0;
      bword_q  <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      tmr_q    <= tmr_d;
      da1_q    <= da1_d;
      da2w_q   <= da2w_d;
      nb_q     <= nb_d;
      done_q   <= done_d;
      scalar_q <= scalar_d;
      bword_q  <= bword_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    tmr_d    = tmr_q;
    da1_d    = da1_q;
    da2w_d   = da2w_q;
    nb_d     = nb_q;
    done_d   = done_q;
    scalar_d = scalar_q;
    bword_d  = bword_q;
    acc_clr  = 1'b0;
    acc_load = 1'b0;
    memA     = '0;
    memB     = '0;
    memC     = '0;
    finish   = 1'b0;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (MatMul_en) begin
          da1_d   = op.dimA1;
          da2w_d  = op.dimA2[7:3];
          nb_d    = op.dimB2[7:3];
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_clr = 1'b1;
          if (op.dimA1 == 8'd0 || op.dimA2[7:3] == 5'd0 || op.dimB2[7:3] == 5'd0)
            state_d = S_DONE;
          else
            state_d = S_READ;
        end
      end
      S_READ: begin
        memA.read    = 1'b1;
        memA.address = addr_a;
        memB.read    = 1'b1;
        memB.address = addr_b;
        state_d      = S_CAPTURE;
      end
      S_CAPTURE: begin
        scalar_d = readdataA[k_q[2:0]*DATA_WIDTH +: DATA_WIDTH];
        bword_d  = readdataB;
        tmr_d    = 3'(MUL_CYCLES - 1);
        state_d  = S_MUL;
      end
      S_MUL: begin
        if (tmr_q == 3'd0) begin
          tmr_d   = 3'(ADD_CYCLES - 1);
          state_d = S_ADD;
        end else begin
          tmr_d = tmr_q - 3'd1;
        end
      end
      S_ADD: begin
        if (tmr_q == 3'd0) begin
          acc_load = 1'b1;
          k_d      = k_q + 8'd1;
          if ({1'b0, k_q} + 9'd1 < {1'b0, da2w_q, 3'b000}) state_d = S_READ;
          else                                             state_d = S_WRITE;
        end else begin
          tmr_d = tmr_q - 3'd1;
        end
      end
      S_WRITE: begin
        memC.write     = 1'b1;
        memC.address   = addr_c;
        memC.writedata = acc_word;
        acc_clr        = 1'b1;
        k_d            = '0;
        state_d        = S_READ;
        if (j_q + 5'd1 == nb_q) begin
          j_d = '0;
          if (i_q + 8'd1 == da1_q) state_d = S_DONE;
          else                     i_d     = i_q + 8'd1;
        end else begin
          j_d = j_q + 5'd1;
        end
      end
      S_DONE: begin
        finish = !done_q;
        done_d = 1'b1;
        if (!MatMul_en) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar l = 0; l < BANDWIDTH; l++) begin : g_lane
    mult_lane u_lane (
      .clk       (clock),
      .rst_n     (reset),
      .a_i       (scalar_q),
      .b_i       (bword_q[l*DATA_WIDTH +: DATA_WIDTH]),
      .acc_clr_i (acc_clr),
      .acc_load_i(acc_load),
      .acc_o     (acc_word[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_mult.sv
module tb_mult;
  import mult_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       MatMul_en;
  meta_data_t op;
  logic [255:0] readdataA, readdataB;
  mem_t       memA, memB, memC;
  logic       finish;

  always #5 clock = ~clock;

  mult dut (
    .clock    (clock),
    .reset    (reset),
    .MatMul_en(MatMul_en),
    .op       (op),
    .readdataA(readdataA),
    .readdataB(readdataB),
    .memA     (memA),
    .memB     (memB),
    .memC     (memC),
    .finish   (finish)
  );

  logic [255:0] mem [0:2047];
  int           ma [16][8];
  int           mb [8][16];
  logic [31:0]  expc [16][16];
  logic [10:0]  wlog [0:127];
  int checks = 0, failures = 0;
  int nrdA = 0, nrdB = 0, nwr = 0, nbad = 0, nfin = 0;
  int lat, s_rd, s_wr, s_fin, s_bad;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i2f(input int v);
    int a, p;
    logic [31:0] r;
    if (v == 0) return 32'd0;
    a = (v < 0) ? -v : v;
    p = 0;
    for (int n = 0; n < 31; n++) if (a[n]) p = n;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'(a << (23 - p));
    return r;
  endfunction

  // One cycle: step to the falling edge and act as memory / monitor.
  task automatic tick();
    @(negedge clock);
    if (memA.read) begin readdataA = mem[memA.address]; nrdA++; end
    if (memB.read) begin readdataB = mem[memB.address]; nrdB++; end
    if (memC.write) begin
      mem[memC.address] = memC.writedata;
      if (nwr < 128) wlog[nwr] = memC.address;
      nwr++;
    end
    if (memA.write || memB.write || memC.read) nbad++;
    if (finish) nfin++;
  endtask

  task automatic load(input int d1, input int d2, input int db2);
    int s;
    for (int i = 0; i < d1; i++)
      for (int k = 0; k < d2; k++)
        mem[DATAA_ADDR + 11'((i*d2 + k)/8)][(k%8)*32 +: 32] = i2f(ma[i][k]);
    for (int k = 0; k < d2; k++)
      for (int c = 0; c < db2; c++)
        mem[DATAB_ADDR + 11'(k*db2/8 + c/8)][(c%8)*32 +: 32] = i2f(mb[k][c]);
    for (int w = 0; w < 64; w++) mem[RES_ADDR + 11'(w)] = {8{32'hDEADBEEF}};
    for (int i = 0; i < d1; i++)
      for (int c = 0; c < db2; c++) begin
        s = 0;
        for (int k = 0; k < d2; k++) s += ma[i][k] * mb[k][c];
        expc[i][c] = i2f(s);
      end
  endtask

  // Start at a falling edge; lat = edges from start edge to finish sampled high.
  task automatic run(input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] db2, output int l);
    op.op_code = MAT_MUL;
    op.dimA1   = d1;
    op.dimA2   = d2;
    op.dimB2   = db2;
    MatMul_en  = 1'b1;
    l = -1;
    for (int c = 1; c <= 6000; c++) begin
      tick();
      if (finish) begin l = c; break; end
    end
  endtask

  task automatic hold_then_drop();
    for (int c = 0; c < 10; c++) tick();
    MatMul_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic verify(input int d1, input int db2, input int wbase);
    logic [255:0] ew;
    int w;
    for (int i = 0; i < d1; i++)
      for (int j = 0; j < db2/8; j++) begin
        w = i*(db2/8) + j;
        for (int l = 0; l < 8; l++) ew[l*32 +: 32] = expc[i][j*8 + l];
        check("c_word", mem[RES_ADDR + 11'(w)], ew);
        check("c_order", wlog[wbase + w], RES_ADDR + 11'(w));
      end
  endtask

  initial begin
    reset     = 1'b0;
    MatMul_en = 1'b0;
    op        = '0;
    readdataA = '0;
    readdataB = '0;
    tick();
    tick();
    check("rst_memA", memA, '0);
    check("rst_memB", memB, '0);
    check("rst_memC", memC, '0);
    check("rst_finish", finish, 0);
    reset = 1'b1;
    tick();
    tick();

    // identity x 1..64
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        ma[i][k] = (i == k) ? 1 : 0;
        mb[i][k] = i*8 + k + 1;
      end
    load(8, 8, 8);
    s_wr = nwr; s_fin = nfin; s_bad = nbad;
    run(8'd8, 8'd8, 8'd8, lat);
    check("t1_latency", lat, 905);
    s_rd = nrdA;
    hold_then_drop();
    check("t1_single_finish", nfin - s_fin, 1);
    check("t1_no_restart", nrdA - s_rd, 0);
    check("t1_writes", nwr - s_wr, 8);
    check("t1_bad_strobes", nbad - s_bad, 0);
    verify(8, 8, s_wr);

    // all 1.0 x all 2.0, inner/column dims carry junk low bits
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        ma[i][k] = 1;
        mb[i][k] = 2;
      end
    load(8, 8, 8);
    check("t2_expect16", expc[3][5], 32'h41800000);
    s_wr = nwr;
    run(8'd8, 8'd11, 8'd13, lat);
    check("t2_latency", lat, 8*1*(14*8 + 1) + 1);
    hold_then_drop();
    check("t2_writes", nwr - s_wr, 8);
    verify(8, 8, s_wr);

    // 16x8 x 8x16 small random integers (exact in single precision)
    for (int i = 0; i < 16; i++)
      for (int k = 0; k < 8; k++) ma[i][k] = int'($urandom_range(16)) - 8;
    for (int k = 0; k < 8; k++)
      for (int c = 0; c < 16; c++) mb[k][c] = int'($urandom_range(16)) - 8;
    load(16, 8, 16);
    s_wr = nwr; s_bad = nbad;
    run(8'd16, 8'd8, 8'd16, lat);
    check("t3_latency", lat, 16*2*(14*8 + 1) + 1);
    hold_then_drop();
    check("t3_writes", nwr - s_wr, 32);
    check("t3_bad_strobes", nbad - s_bad, 0);
    verify(16, 16, s_wr);

    // zero dimension
    s_wr = nwr; s_rd = nrdA + nrdB;
    run(8'd0, 8'd8, 8'd8, lat);
    check("t4_latency", lat, 1);
    hold_then_drop();
    check("t4_no_reads", nrdA + nrdB - s_rd, 0);
    check("t4_no_writes", nwr - s_wr, 0);

    // reset during ADD, then a full restart
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        ma[i][k] = (i == k) ? 2 : 0;
        mb[i][k] = 64 - (i*8 + k);
      end
    load(8, 8, 8);
    op.op_code = MAT_MUL; op.dimA1 = 8'd8; op.dimA2 = 8'd8; op.dimB2 = 8'd8;
    MatMul_en = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    reset = 1'b0;
    #1;
    check("t5_rst_memA", memA, '0);
    check("t5_rst_memB", memB, '0);
    check("t5_rst_memC", memC, '0);
    check("t5_rst_finish", finish, 0);
    MatMul_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    s_wr = nwr;
    run(8'd8, 8'd8, 8'd8, lat);
    check("t5_latency", lat, 905);
    hold_then_drop();
    check("t5_writes", nwr - s_wr, 8);
    verify(8, 8, s_wr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
